apb_slave_regbank: RTL and testbench

APB completer holding a bank of NREG DW-bit memory-mapped registers with byte-strobe writes, a configurable wait-state count and error responses. It sits directly downstream of the team's APB master. It accepts that master's phase signalling, where i_psel is high only in the setup cycle and i_penable alone marks the access phase, as well as standard APB4 signalling. Register contents are exported flat for the hardware that consumes them. Read-only slots return live hardware status.

---
 rtl/apb_slave_regbank.sv | 101 ++++++++++
 tb/tb_apb_slave_regbank.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB completer with byte-strobed register bank, wait states and error responses
module apb_slave_regbank #(
    parameter int              DW      = 32,
    parameter int              AW      = 8,
    parameter int              NREG    = 16,
    parameter int              WAIT    = 0,
    parameter logic [NREG-1:0] RO_MASK = '0
) (
    input  logic               pclk,
    input  logic               presetn,
    input  logic [AW-1:0]      i_paddr,
    input  logic               i_pwrite,
    input  logic               i_psel,
    input  logic               i_penable,
    input  logic [DW-1:0]      i_pwdata,
    input  logic [DW/8-1:0]    i_pstrb,
    output logic [DW-1:0]      o_prdata,
    output logic               o_pslverr,
    output logic               o_pready,
    input  logic [NREG*DW-1:0] i_hw_data,
    output logic [NREG*DW-1:0] o_regs
);

    localparam int SW = DW / 8;
    localparam int BW = $clog2(SW);
    localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

    typedef enum logic {
        S_IDLE,
        S_ACCESS
    } state_t;

    state_t           r_state;
    logic [3:0]       r_wcnt;
    logic [DW-1:0]    r_regs [NREG];

    logic [AW-1:0]    w_idx_full;
    logic [IW-1:0]    w_idx;
    logic             w_bad;
    logic             w_rofault;
    logic             w_err;
    logic             w_done;
    logic [DW-1:0]    w_rdval;

    // Shift/mask form keeps the decode legal when SW == 1 (no byte-offset bits).
    assign w_idx_full = i_paddr >> BW;
    assign w_idx      = w_idx_full[IW-1:0];
    assign w_bad      = ({1'b0, w_idx_full} >= (AW+1)'(NREG))
                      | ((i_paddr & AW'(SW - 1)) != '0);
    assign w_rofault  = i_pwrite & !w_bad & RO_MASK[w_idx];
    assign w_err      = w_bad | w_rofault;

    assign w_done     = (r_state == S_ACCESS) & i_penable & (r_wcnt == 4'd0);
    assign w_rdval    = RO_MASK[w_idx] ? i_hw_data[w_idx*DW +: DW] : r_regs[w_idx];

    assign o_pready   = w_done;
    assign o_pslverr  = w_done & w_err;
    assign o_prdata   = (w_done & !i_pwrite & !w_err) ? w_rdval : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= S_IDLE;
            r_wcnt  <= 4'd0;
            for (int r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_psel && !i_penable) begin
                        r_state <= S_ACCESS;
                        r_wcnt  <= 4'(WAIT);
                    end
                end
                S_ACCESS: begin
                    // Dropping i_penable mid-access just freezes the transfer.
                    if (i_penable) begin
                        if (r_wcnt != 4'd0) begin
                            r_wcnt <= r_wcnt - 4'd1;
                        end else begin
                            r_state <= S_IDLE;
                            if (i_pwrite && !w_err) begin
                                for (int k = 0; k < SW; k++) begin
                                    if (i_pstrb[k]) begin
                                        r_regs[w_idx][k*8 +: 8] <= i_pwdata[k*8 +: 8];
                                    end
                                end
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_out
        assign o_regs[g*DW +: DW] = RO_MASK[g] ? '0 : r_regs[g];
    end

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - directed self-checking bench for apb_slave_regbank
module tb_apb_slave_regbank;

    logic         pclk = 1'b0;
    logic         presetn = 1'b0;
    logic [7:0]   paddr = '0;
    logic         pwrite = 1'b0;
    logic         psel = 1'b0;
    logic         penable = 1'b0;
    logic [31:0]  pwdata = '0;
    logic [3:0]   pstrb = '0;
    logic [31:0]  o_prdata;
    logic         o_pslverr;
    logic         o_pready;
    logic [511:0] hw_data = '0;
    logic [511:0] o_regs;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0]  rd;
    logic         er;
    int           cyc;
    longint       tdone;
    longint       t_a [3];
    longint       t_b [3];
    logic [31:0]  d_a [3];
    logic [31:0]  d_b [3];
    logic [511:0] exp_regs;

    always #5 pclk = ~pclk;

    apb_slave_regbank #(
        .DW(32), .AW(8), .NREG(16), .WAIT(2), .RO_MASK(16'h8000)
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .i_paddr(paddr), .i_pwrite(pwrite), .i_psel(psel), .i_penable(penable),
        .i_pwdata(pwdata), .i_pstrb(pstrb),
        .o_prdata(o_prdata), .o_pslverr(o_pslverr), .o_pready(o_pready),
        .i_hw_data(hw_data), .o_regs(o_regs)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] a, input logic w, input logic [31:0] d,
                        input logic [3:0] s, input logic apb4);
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d; pstrb = s;
        @(posedge pclk); #1;
        psel = apb4; penable = 1'b1; cyc = 1;
        while (!o_pready && cyc < 20) begin
            @(posedge pclk); #1;
            cyc++;
        end
        rd = o_prdata;
        er = o_pslverr;
        tdone = $time;
    endtask

    task automatic do_write(input string tag, input logic [7:0] a, input logic [31:0] d,
                            input logic [3:0] s, input logic exp_err);
        xfer(a, 1'b1, d, s, 1'b0);
        check({tag, "_cyc"}, 512'(cyc), 512'd3);
        check({tag, "_err"}, 512'(er), 512'(exp_err));
    endtask

    task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                           input logic exp_err);
        xfer(a, 1'b0, 32'h0, 4'h0, 1'b0);
        check({tag, "_cyc"}, 512'(cyc), 512'd3);
        check({tag, "_data"}, 512'(rd), 512'(exp_d));
        check({tag, "_err"}, 512'(er), 512'(exp_err));
    endtask

    initial begin
        hw_data[15*32 +: 32] = 32'hCAFE0001;
        hw_data[1*32 +: 32]  = 32'h55555555;
        repeat (2) @(posedge pclk);
        #1;
        check("rst_pready", 512'(o_pready), 512'd0);
        check("rst_pslverr", 512'(o_pslverr), 512'd0);
        check("rst_prdata", 512'(o_prdata), 512'd0);
        check("rst_regs", o_regs, 512'd0);
        presetn = 1'b1;

        xfer(8'h04, 1'b1, 32'hDEADBEEF, 4'hF, 1'b0);
        check("wr1_cyc", 512'(cyc), 512'd3);
        check("wr1_err", 512'(er), 512'd0);
        check("wr1_regs_during", 512'(o_regs[32 +: 32]), 512'd0);
        @(posedge pclk); #1;
        check("wr1_regs_after", 512'(o_regs[32 +: 32]), 512'(32'hDEADBEEF));
        do_read("rd1", 8'h04, 32'hDEADBEEF, 1'b0);

        do_write("wr_part", 8'h04, 32'h11223344, 4'b0101, 1'b0);
        do_read("rd_part", 8'h04, 32'hDE22BE44, 1'b0);
        do_write("wr_nostrb", 8'h04, 32'hFFFFFFFF, 4'h0, 1'b0);
        do_read("rd_nostrb", 8'h04, 32'hDE22BE44, 1'b0);

        exp_regs = '0;
        exp_regs[32 +: 32] = 32'hDE22BE44;
        do_write("wr_oor", 8'h40, 32'h01010101, 4'hF, 1'b1);
        do_write("wr_mis", 8'h05, 32'h02020202, 4'hF, 1'b1);
        @(posedge pclk); #1;
        check("err_regs", o_regs, exp_regs);
        do_read("rd_oor", 8'h40, 32'h0, 1'b1);
        do_read("rd_mis", 8'h05, 32'h0, 1'b1);

        do_read("rd_ro", 8'h3C, 32'hCAFE0001, 1'b0);
        do_write("wr_ro", 8'h3C, 32'h77777777, 4'hF, 1'b1);
        @(posedge pclk); #1;
        check("ro_regs15", 512'(o_regs[15*32 +: 32]), 512'd0);
        check("ro_regs_all", o_regs, exp_regs);

        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; paddr = 8'h08; pwrite = 1'b1;
        pwdata = 32'h12345678; pstrb = 4'hF;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        check("abort_pready", 512'(o_pready), 512'd0);
        check("abort_pslverr", 512'(o_pslverr), 512'd0);
        check("abort_prdata", 512'(o_prdata), 512'd0);
        check("abort_regs", o_regs, 512'd0);
        repeat (3) @(posedge pclk);
        #1;
        check("abort_held", 512'(o_pready), 512'd0);
        penable = 1'b0;
        presetn = 1'b1;
        do_write("wr_post", 8'h08, 32'hA5A5A5A5, 4'hF, 1'b0);
        @(posedge pclk); #1;
        check("post_regs2", 512'(o_regs[2*32 +: 32]), 512'(32'hA5A5A5A5));
        check("post_regs1", 512'(o_regs[32 +: 32]), 512'd0);

        xfer(8'h0C, 1'b1, 32'h0BADF00D, 4'hF, 1'b0); t_a[0] = tdone; d_a[0] = rd;
        xfer(8'h10, 1'b1, 32'h600DCAFE, 4'hF, 1'b0); t_a[1] = tdone; d_a[1] = rd;
        xfer(8'h0C, 1'b0, 32'h0, 4'h0, 1'b0);        t_a[2] = tdone; d_a[2] = rd;
        xfer(8'h0C, 1'b1, 32'h13579BDF, 4'hF, 1'b1); t_b[0] = tdone; d_b[0] = rd;
        xfer(8'h10, 1'b0, 32'h0, 4'h0, 1'b1);        t_b[1] = tdone; d_b[1] = rd;
        xfer(8'h0C, 1'b0, 32'h0, 4'h0, 1'b1);        t_b[2] = tdone; d_b[2] = rd;
        check("b2b_team_gap0", 512'(t_a[1] - t_a[0]), 512'd40);
        check("b2b_team_gap1", 512'(t_a[2] - t_a[1]), 512'd40);
        check("b2b_apb4_gap0", 512'(t_b[0] - t_a[2]), 512'd40);
        check("b2b_apb4_gap1", 512'(t_b[1] - t_b[0]), 512'd40);
        check("b2b_apb4_gap2", 512'(t_b[2] - t_b[1]), 512'd40);
        check("b2b_team_rd", 512'(d_a[2]), 512'(32'h0BADF00D));
        check("b2b_apb4_rd10", 512'(d_b[1]), 512'(32'h600DCAFE));
        check("b2b_apb4_rd0c", 512'(d_b[2]), 512'(32'h13579BDF));
        check("b2b_wr_rdata0", 512'(d_b[0]), 512'd0);

        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
